int_port_dispatch_queue: RTL and testbench

- Per-ALU-port in-order dispatch FIFO directly downstream of the integer scheduler.
- Each cycle it takes the decode group (up to `DEC_WIDTH uops) plus the scheduler's port assignment, and enqueues in program order the uops steered to its own port.
- It presents one uop per cycle to that port's issue queue with a valid/ready handshake.
- It applies backpressure to decode/rename and truncates speculative entries on branch flush; one instance exists per port (NUM_ALUS instances).

---
 rtl/int_port_dispatch_queue_pkg.sv | 42 ++++
 rtl/int_port_dispatch_queue_lane_compactor.sv | 23 ++
 rtl/int_port_dispatch_queue.sv | 142 ++++++++++++++
 tb/tb_int_port_dispatch_queue.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/int_port_dispatch_queue_pkg.sv
// Shared integer-backend types for the per-port dispatch queues, plus the SqN age helper
// that the ROB and LSU flush logic also use.
`ifndef DEC_WIDTH
`define DEC_WIDTH 4
`endif

package int_port_dispatch_queue_pkg;

  localparam int unsigned NUM_ALUS         = 4;
  localparam int unsigned DEC_W            = `DEC_WIDTH;
  localparam int unsigned DISPATCH_Q_DEPTH = 8;
  localparam int unsigned SQN_W            = 7;

  typedef logic [SQN_W-1:0]            SqN;
  typedef logic [$clog2(NUM_ALUS)-1:0] IntUOpOrder_t;

  typedef enum logic [2:0] {
    FU_INT    = 3'd0,
    FU_MUL    = 3'd1,
    FU_DIV    = 3'd2,
    FU_BRANCH = 3'd3,
    FU_CSR    = 3'd4,
    FU_RN     = 3'd5,
    FU_AGU    = 3'd6,
    FU_TRAP   = 3'd7
  } FuncUnit;

  typedef struct packed {
    logic        valid;
    FuncUnit     fu;
    logic [5:0]  opcode;
    logic [31:0] imm;
  } D_UOp;

  // a is younger than b when the modular difference is positive
  function automatic logic SqNYounger(input SqN a, input SqN b);
    SqN d;
    d = a - b;
    return $signed(d) > $signed(SqN'(0));
  endfunction

endpackage

// File: rtl/int_port_dispatch_queue_lane_compactor.sv
// Prefix-sum network: turns a lane-select mask into packed write offsets and a selected count.
module lane_compactor #(
  parameter int unsigned DW = 4,
  parameter int unsigned CW = $clog2(DW + 1)
) (
  input  logic [DW-1:0]         sel,
  output logic [DW-1:0][CW-1:0] offs,
  output logic [CW-1:0]         cnt
);

  logic [CW-1:0] acc;

  always_comb begin
    acc  = '0;
    offs = '0;
    for (int unsigned i = 0; i < DW; i++) begin
      offs[i] = acc;
      acc     = acc + CW'(sel[i]);
    end
    cnt = acc;
  end

endmodule

// File: rtl/int_port_dispatch_queue.sv
// In-order dispatch FIFO for one integer ALU port, with flush truncation and registered stall.
// Optional same-cycle bypass from the decode group when empty: define DISPATCH_BYPASS_EN.
module int_port_dispatch_queue
  import int_port_dispatch_queue_pkg::*;
#(
  parameter int unsigned PORT  = 0,
  parameter int unsigned DEPTH = DISPATCH_Q_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         IN_flush,
  input  SqN           IN_flushSqN,
  input  logic         IN_valid,
  input  D_UOp         IN_uop    [`DEC_WIDTH-1:0],
  input  SqN           IN_uopSqN [`DEC_WIDTH-1:0],
  input  IntUOpOrder_t IN_order  [`DEC_WIDTH-1:0],
  output logic         OUT_stall,
  output logic         OUT_valid,
  output D_UOp         OUT_uop,
  output SqN           OUT_uopSqN,
  input  logic         IN_ready
);

  localparam int unsigned DW = DEC_W;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(DW + 1);

  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic          stall_q, stall_d;

  D_UOp          uop_mem_q [DEPTH];
  SqN            sqn_mem_q [DEPTH];

  logic [DW-1:0]         sel;
  logic [DW-1:0][CW-1:0] offs;
  logic [CW-1:0]         sel_cnt;

  always_comb begin
    for (int unsigned i = 0; i < DW; i++) begin
      sel[i] = IN_valid && IN_uop[i].valid && (IN_order[i] == IntUOpOrder_t'(PORT)) &&
               !(IN_uop[i].fu inside {FU_RN, FU_AGU, FU_TRAP});
    end
  end

  lane_compactor #(.DW(DW), .CW(CW)) u_compactor (
    .sel  (sel),
    .offs (offs),
    .cnt  (sel_cnt)
  );

  logic [PW-1:0] count, count_next, keep;
  logic [PW:0]   free_next;
  logic [AW-1:0] slot;
  logic          empty, head_flushed, deq, bypass, byp_take;
  D_UOp          head_uop, byp_uop;
  SqN            head_sqn, byp_sqn;
  logic [DW-1:0]         wr_en;
  logic [DW-1:0][AW-1:0] wr_slot;

  always_comb begin
    count        = wrPtr_q - rdPtr_q;
    empty        = (count == '0);
    head_uop     = uop_mem_q[rdPtr_q[AW-1:0]];
    head_sqn     = sqn_mem_q[rdPtr_q[AW-1:0]];
    head_flushed = IN_flush && SqNYounger(head_sqn, IN_flushSqN);

    // Younger entries are a tail suffix, so counting survivors gives the new tail directly
    keep = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot = rdPtr_q[AW-1:0] + AW'(i);
      if ((PW'(i) < count) && !SqNYounger(sqn_mem_q[slot], IN_flushSqN)) begin
        keep = keep + PW'(1);
      end
    end

`ifdef DISPATCH_BYPASS_EN
    bypass  = empty && !IN_flush && (sel_cnt != '0);
    byp_uop = IN_uop[0];
    byp_sqn = IN_uopSqN[0];
    for (int unsigned i = DW; i > 0; i--) begin
      if (sel[i-1]) begin
        byp_uop = IN_uop[i-1];
        byp_sqn = IN_uopSqN[i-1];
      end
    end
`else
    bypass  = 1'b0;
    byp_uop = '0;
    byp_sqn = '0;
`endif

    OUT_valid  = bypass || (!empty && !head_flushed);
    OUT_uop    = bypass ? byp_uop : head_uop;
    OUT_uopSqN = bypass ? byp_sqn : head_sqn;

    deq      = !empty && !head_flushed && IN_ready;
    byp_take = bypass && IN_ready;

    // A bypassed head takes offset 0, so the rest shift down by one slot
    for (int unsigned i = 0; i < DW; i++) begin
      wr_en[i]   = !IN_flush && sel[i] && !(byp_take && (offs[i] == '0));
      wr_slot[i] = wrPtr_q[AW-1:0] + AW'(offs[i]) - AW'(byp_take);
    end

    rdPtr_d = rdPtr_q + PW'(deq);
    if (IN_flush) begin
      wrPtr_d = rdPtr_q + keep;
    end else begin
      wrPtr_d = wrPtr_q + PW'(sel_cnt) - PW'(byp_take);
    end

    count_next = wrPtr_d - rdPtr_d;
    free_next  = (PW+1)'(DEPTH) - {1'b0, count_next};
    stall_d    = free_next < (PW+1)'(DW);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      stall_q <= 1'b0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      stall_q <= stall_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DW; i++) begin
      if (wr_en[i]) begin
        uop_mem_q[wr_slot[i]] <= IN_uop[i];
        sqn_mem_q[wr_slot[i]] <= IN_uopSqN[i];
      end
    end
  end

  assign OUT_stall = stall_q;

endmodule

// File: tb/tb_int_port_dispatch_queue.sv
// Bench for int_port_dispatch_queue (PORT=1, default build): directed vector table,
// async-reset sequence, and random traffic against a queue-based reference model.
module tb_int_port_dispatch_queue;
  import int_port_dispatch_queue_pkg::*;

  localparam int DW      = DEC_W;
  localparam int DEPTH   = DISPATCH_Q_DEPTH;
  localparam int SQN_MOD = 1 << SQN_W;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_flush;
  SqN           in_fsqn;
  logic         in_valid;
  D_UOp         in_uop [DW-1:0];
  SqN           in_sqn [DW-1:0];
  IntUOpOrder_t in_ord [DW-1:0];
  logic         out_stall, out_valid, in_ready;
  D_UOp         out_uop;
  SqN           out_sqn;

  int n_checks = 0;
  int n_pass   = 0;

  int_port_dispatch_queue #(.PORT(1), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .IN_flush   (in_flush),
    .IN_flushSqN(in_fsqn),
    .IN_valid   (in_valid),
    .IN_uop     (in_uop),
    .IN_uopSqN  (in_sqn),
    .IN_order   (in_ord),
    .OUT_stall  (out_stall),
    .OUT_valid  (out_valid),
    .OUT_uop    (out_uop),
    .OUT_uopSqN (out_sqn),
    .IN_ready   (in_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    bit         v;
    logic [7:0] ord;
    logic [3:0] lv;
    logic [3:0] agu;
    SqN         base;
    bit         fl;
    SqN         fs;
    bit         rdy;
    bit         ev;
    SqN         es;
    bit         est;
  } vec_t;

  vec_t tbl[$];

  task automatic drive(input bit v, input logic [7:0] ord, input logic [3:0] lv,
                       input logic [3:0] agu, input SqN base, input bit fl, input SqN fs,
                       input bit rdy);
    in_valid = v;
    in_flush = fl;
    in_fsqn  = fs;
    in_ready = rdy;
    for (int i = 0; i < DW; i++) begin
      in_uop[i].valid  = lv[i];
      in_uop[i].fu     = agu[i] ? FU_AGU : FU_INT;
      in_uop[i].opcode = 6'(i);
      in_uop[i].imm    = 32'(base) + 32'(i);
      in_sqn[i]        = SqN'(int'(base) + i);
      in_ord[i]        = IntUOpOrder_t'(ord[2*i +: 2]);
    end
  endtask

  // Reference model: an ordered list of resident entries
  typedef struct { SqN sqn; D_UOp uop; } ent_t;
  ent_t mq[$];
  ent_t keepq[$];
  bit   mstall;

  function automatic bit m_younger(input SqN a, input SqN b);
    int d;
    d = (int'(a) - int'(b) + SQN_MOD) % SQN_MOD;
    return (d > 0) && (d < SQN_MOD / 2);
  endfunction

  initial begin
    bit ev;
    int nsqn;
    int r;

    rst = 1'b1;
    drive(0, 8'h00, 4'h0, 4'h0, '0, 0, '0, 1);
    #12;
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_stall", out_stall, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("idle%0d_valid", c), out_valid, 1'b0);
      chk($sformatf("idle%0d_stall", c), out_stall, 1'b0);
    end

    //              v  ord    lv    agu   base  fl fs   rdy ev es   est
    tbl.push_back('{0, 8'h00, 4'h0, 4'h0, 0,    0, 0,   1,  0, 0,   0});
    tbl.push_back('{1, 8'h51, 4'hF, 4'h0, 10,   0, 0,   1,  0, 0,   0});
    tbl.push_back('{0, 8'h00, 4'h0, 4'h0, 0,    0, 0,   1,  1, 10,  0});
    tbl.push_back('{0, 8'h00, 4'h0, 4'h0, 0,    0, 0,   1,  1, 12,  0});
    tbl.push_back('{0, 8'h00, 4'h0, 4'h0, 0,    0, 0,   1,  1, 13,  0});
    tbl.push_back('{0, 8'h00, 4'h0, 4'h0, 0,    0, 0,   1,  0, 0,   0});
    tbl.push_back('{1, 8'h55, 4'hF, 4'h0, 20,   0, 0,   0,  0, 0,   0});
    tbl.push_back('{1, 8'h55, 4'hF, 4'h0, 24,   0, 0,   0,  1, 20,  0});
    tbl.push_back('{0, 8'h00, 4'h0, 4'h0, 0,    0, 0,   0,  1, 20,  1});
    tbl.push_back('{0, 8'h00, 4'h0, 4'h0, 0,    0, 0,   1,  1, 20,  1});
    tbl.push_back('{0, 8'h00, 4'h0, 4'h0, 0,    0, 0,   1,  1, 21,  1});
    tbl.push_back('{0, 8'h00, 4'h0, 4'h0, 0,    0, 0,   1,  1, 22,  1});
    tbl.push_back('{0, 8'h00, 4'h0, 4'h0, 0,    0, 0,   1,  1, 23,  1});
    tbl.push_back('{0, 8'h00, 4'h0, 4'h0, 0,    0, 0,   0,  1, 24,  0});
    tbl.push_back('{1, 8'h55, 4'hF, 4'h0, 28,   1, 25,  0,  1, 24,  0});
    tbl.push_back('{0, 8'h00, 4'h0, 4'h0, 0,    0, 0,   1,  1, 24,  0});
    tbl.push_back('{0, 8'h00, 4'h0, 4'h0, 0,    0, 0,   1,  1, 25,  0});
    tbl.push_back('{0, 8'h00, 4'h0, 4'h0, 0,    0, 0,   1,  0, 0,   0});
    tbl.push_back('{1, 8'h55, 4'hF, 4'h0, 30,   0, 0,   0,  0, 0,   0});
    tbl.push_back('{0, 8'h00, 4'h0, 4'h0, 0,    1, 29,  1,  0, 0,   0});
    tbl.push_back('{0, 8'h00, 4'h0, 4'h0, 0,    0, 0,   1,  0, 0,   0});
    tbl.push_back('{1, 8'h55, 4'hF, 4'h0, 126,  0, 0,   0,  0, 0,   0});
    tbl.push_back('{0, 8'h00, 4'h0, 4'h0, 0,    1, 127, 0,  1, 126, 0});
    tbl.push_back('{0, 8'h00, 4'h0, 4'h0, 0,    0, 0,   1,  1, 126, 0});
    tbl.push_back('{0, 8'h00, 4'h0, 4'h0, 0,    0, 0,   1,  1, 127, 0});
    tbl.push_back('{0, 8'h00, 4'h0, 4'h0, 0,    0, 0,   1,  0, 0,   0});
    tbl.push_back('{1, 8'h55, 4'hB, 4'h2, 40,   0, 0,   1,  0, 0,   0});
    tbl.push_back('{0, 8'h00, 4'h0, 4'h0, 0,    0, 0,   1,  1, 40,  0});
    tbl.push_back('{0, 8'h00, 4'h0, 4'h0, 0,    0, 0,   1,  1, 43,  0});
    tbl.push_back('{0, 8'h00, 4'h0, 4'h0, 0,    0, 0,   1,  0, 0,   0});

    foreach (tbl[k]) begin
      @(negedge clk);
      drive(tbl[k].v, tbl[k].ord, tbl[k].lv, tbl[k].agu, tbl[k].base, tbl[k].fl, tbl[k].fs,
            tbl[k].rdy);
      #1;
      chk($sformatf("row%0d_valid", k), out_valid, tbl[k].ev);
      chk($sformatf("row%0d_stall", k), out_stall, tbl[k].est);
      if (tbl[k].ev) chk($sformatf("row%0d_sqn", k), out_sqn, tbl[k].es);
    end

    // Async reset with five resident entries
    @(negedge clk);
    drive(1, 8'h55, 4'hF, 4'h0, 50, 0, 0, 0);
    @(negedge clk);
    drive(1, 8'h01, 4'h1, 4'h0, 54, 0, 0, 0);
    @(negedge clk);
    drive(0, 8'h00, 4'h0, 4'h0, 0, 0, 0, 0);
    #1;
    chk("pre_rst_valid", out_valid, 1'b1);
    chk("pre_rst_sqn", out_sqn, 7'd50);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_stall", out_stall, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      in_ready = 1'b1;
      #1;
      chk($sformatf("post_rst%0d_valid", c), out_valid, 1'b0);
    end

    // Random traffic against the reference model
    @(negedge clk);
    rst = 1'b1;
    #2 rst = 1'b0;
    mq.delete();
    mstall = 1'b0;
    nsqn   = 5;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      in_flush = ($urandom_range(0, 11) == 0);
      r        = int'($urandom_range(0, 12));
      in_fsqn  = SqN'(nsqn - 1 - r);
      in_ready = ($urandom_range(0, 9) < 7);
      in_valid = !mstall && ($urandom_range(0, 9) < 7);
      for (int i = 0; i < DW; i++) begin
        in_uop[i].valid  = ($urandom_range(0, 9) < 9);
        in_uop[i].fu     = FuncUnit'($urandom_range(0, 7));
        in_uop[i].opcode = 6'($urandom);
        in_uop[i].imm    = $urandom;
        in_sqn[i]        = SqN'(nsqn + i);
        in_ord[i]        = $urandom_range(0, 1) ? IntUOpOrder_t'(1)
                                                : IntUOpOrder_t'($urandom_range(0, NUM_ALUS-1));
      end
      #1;
      ev = (mq.size() > 0) && !(in_flush && m_younger(mq[0].sqn, in_fsqn));
      chk("rnd_valid", out_valid, ev);
      chk("rnd_stall", out_stall, mstall);
      if (ev) begin
        chk("rnd_sqn", out_sqn, mq[0].sqn);
        chk("rnd_uop", out_uop, mq[0].uop);
      end

      if (ev && in_ready) void'(mq.pop_front());
      if (in_flush) begin
        keepq.delete();
        foreach (mq[k]) if (!m_younger(mq[k].sqn, in_fsqn)) keepq.push_back(mq[k]);
        mq = keepq;
        nsqn = int'(in_fsqn) + 1;
      end else if (in_valid) begin
        for (int i = 0; i < DW; i++) begin
          if (in_uop[i].valid && in_ord[i] == IntUOpOrder_t'(1) &&
              !(in_uop[i].fu inside {FU_RN, FU_AGU, FU_TRAP}))
            mq.push_back('{in_sqn[i], in_uop[i]});
        end
        nsqn = nsqn + DW;
      end
      mstall = (DEPTH - mq.size()) < DW;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
